alu_exec_ctrl: RTL and testbench

- Execute-stage controller that owns the 8-bit combinational ALU (a, b, s, ci -> co, out) and sequences operations into it for the CPU decoder.
- Accepts one operation at a time over a valid/ready request handshake.
- Maintains the architectural carry and zero flags.
- Adds a multi-cycle 8x8 unsigned multiply that reuses the ALU ADD path, one ALU add per cycle.
- Returns results over a valid/ready response handshake.

---
 rtl/alu_exec_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: sequences single ALU ops and a shift-add 8x8 multiply
// through an external combinational ALU, owning the carry/zero flags.
module alu_exec_ctrl #(
    parameter int MUL_STEPS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_use_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_hi,
    output logic [7:0] rsp_lo,
    output logic       flag_c,
    output logic       flag_z,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_s,
    output logic       alu_ci,
    input  logic       alu_co,
    input  logic [7:0] alu_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_CMP  = 4'b1111;
    localparam logic [3:0] CNT_LAST = 4'(MUL_STEPS - 1);

    logic [1:0] state_q, state_d;
    logic [4:0] op_q, op_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic       ci_q, ci_d;
    logic [7:0] acc_q, acc_d, mq_q, mq_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
    logic       flag_c_q, flag_c_d, flag_z_q, flag_z_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        ci_d     = ci_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        cnt_d    = cnt_q;
        rsp_hi_d = rsp_hi_q;
        rsp_lo_d = rsp_lo_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_s    = 4'h0;
        alu_ci   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    // Carry-in is frozen at accept; later flag updates must not leak in.
                    ci_d = req_use_c & flag_c_q;
                    if (req_op == OP_MUL) begin
                        acc_d   = 8'h00;
                        mq_d    = req_b;
                        cnt_d   = 4'd0;
                        state_d = MUL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                alu_s   = op_q[3:0];
                alu_ci  = ci_q;
                state_d = RESP;
                rsp_hi_d = 8'h00;
                if (op_q[4]) begin
                    rsp_lo_d = 8'h00;
                end else if (op_q[3:0] == ALU_CMP) begin
                    rsp_lo_d = 8'h00;
                    flag_z_d = (a_q == b_q);
                end else begin
                    rsp_lo_d = alu_out;
                    flag_c_d = alu_co;
                    flag_z_d = (alu_out == 8'h00);
                end
            end
            MUL: begin
                alu_a  = acc_q;
                alu_b  = mq_q[0] ? a_q : 8'h00;
                alu_s  = ALU_ADD;
                alu_ci = 1'b0;
                // Shift the 9-bit sum right across acc:mq; product ends up in {acc, mq}.
                acc_d  = {alu_co, alu_out[7:1]};
                mq_d   = {alu_out[0], mq_q[7:1]};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = RESP;
                    rsp_hi_d = acc_d;
                    rsp_lo_d = mq_d;
                    flag_c_d = 1'b0;
                    flag_z_d = ({acc_d, mq_d} == 16'h0000);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 5'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            ci_q     <= 1'b0;
            acc_q    <= 8'h00;
            mq_q     <= 8'h00;
            cnt_q    <= 4'd0;
            rsp_hi_q <= 8'h00;
            rsp_lo_q <= 8'h00;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ci_q     <= ci_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            cnt_q    <= cnt_d;
            rsp_hi_q <= rsp_hi_d;
            rsp_lo_q <= rsp_lo_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_hi    = rsp_hi_q;
    assign rsp_lo    = rsp_lo_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU attached to its alu_* port.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready;
    logic [4:0] req_op;
    logic [7:0] req_a, req_b;
    logic       req_use_c;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_hi, rsp_lo;
    logic       flag_c, flag_z;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_s;
    logic       alu_ci, alu_co;
    logic [7:0] alu_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference ALU: 01xx adds with carry-in, everything else is XOR with no carry.
    always_comb begin
        if (alu_s[3:2] == 2'b01) {alu_co, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
        else                     {alu_co, alu_out} = {1'b0, alu_a ^ alu_b};
    end

    alu_exec_ctrl #(.MUL_STEPS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_use_c(req_use_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .flag_c(flag_c), .flag_z(flag_z),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_ci(alu_ci),
        .alu_co(alu_co), .alu_out(alu_out)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request at the falling edge, let the next rising edge accept it.
    task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic use_c);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_c = use_c;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Edges counted from the accepting edge (edge 1) until rsp_valid is seen.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int edges = 1;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check({tag, "_lat"}, 16'(edges), 16'(exp_lat));
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                             input logic c, input logic z);
        check({tag, "_hi"}, {8'h00, rsp_hi}, {8'h00, hi});
        check({tag, "_lo"}, {8'h00, rsp_lo}, {8'h00, lo});
        check({tag, "_c"},  {15'd0, flag_c}, {15'd0, c});
        check({tag, "_z"},  {15'd0, flag_z}, {15'd0, z});
    endtask

    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rvld_clr"}, {15'd0, rsp_valid}, 16'd0);
        check({tag, "_rdy_back"}, {15'd0, req_ready}, 16'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_a = 8'h00; req_b = 8'h00;
        req_use_c = 1'b0; rsp_ready = 1'b0;
        #12;
        check("rst_req_ready", {15'd0, req_ready}, 16'd1);
        check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check_rsp("rst", 8'h00, 8'h00, 1'b0, 1'b0);
        check("rst_alu_drive", {alu_a, alu_b}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD F0+20 -> 10 carry out
        issue(5'b00100, 8'hF0, 8'h20, 1'b0);
        wait_rsp("add", 2);
        check_rsp("add", 8'h00, 8'h10, 1'b1, 1'b0);
        take_rsp("add");

        // ADC with sampled carry, then without
        issue(5'b00101, 8'h01, 8'h01, 1'b1);
        wait_rsp("adc1", 2);
        check_rsp("adc1", 8'h00, 8'h03, 1'b0, 1'b0);
        take_rsp("adc1");
        issue(5'b00101, 8'h01, 8'h01, 1'b0);
        wait_rsp("adc0", 2);
        check_rsp("adc0", 8'h00, 8'h02, 1'b0, 1'b0);
        take_rsp("adc0");

        // MUL FF*FF = FE01; first step adds a (mq[0]=1) onto acc=0
        issue(5'b10000, 8'hFF, 8'hFF, 1'b0);
        check("mul_alu_s", {12'd0, alu_s}, 16'h0004);
        check("mul_alu_ab", {alu_a, alu_b}, 16'h00FF);
        wait_rsp("mulff", 9);
        check_rsp("mulff", 8'hFE, 8'h01, 1'b0, 1'b0);
        take_rsp("mulff");

        issue(5'b10000, 8'h00, 8'h37, 1'b0);
        wait_rsp("mul0", 9);
        check_rsp("mul0", 8'h00, 8'h00, 1'b0, 1'b1);
        take_rsp("mul0");

        // Preset C, then CMP equal operands, then NOP keeps flags
        issue(5'b00100, 8'hF0, 8'h20, 1'b0);
        wait_rsp("cpre", 2);
        take_rsp("cpre");
        issue(5'b01111, 8'h5A, 8'h5A, 1'b0);
        wait_rsp("cmp", 2);
        check_rsp("cmp", 8'h00, 8'h00, 1'b1, 1'b1);
        take_rsp("cmp");
        issue(5'b10101, 8'h12, 8'h34, 1'b1);
        wait_rsp("nop", 2);
        check_rsp("nop", 8'h00, 8'h00, 1'b1, 1'b1);
        take_rsp("nop");

        // Backpressure with a competing request held valid
        issue(5'b00100, 8'h01, 8'h02, 1'b0);
        wait_rsp("bp", 2);
        req_valid = 1'b1; req_op = 5'b00100; req_a = 8'h10; req_b = 8'h10; req_use_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {15'd0, rsp_valid}, 16'd1);
            check("bp_req_ready", {15'd0, req_ready}, 16'd0);
            check_rsp("bp_hold", 8'h00, 8'h03, 1'b0, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        take_rsp("bp");
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("bp2", 2);
        check_rsp("bp2", 8'h00, 8'h20, 1'b0, 1'b0);
        take_rsp("bp2");

        // Reset in the middle of a MUL, with C set beforehand
        issue(5'b00100, 8'hF0, 8'h20, 1'b0);
        wait_rsp("rpre", 2);
        take_rsp("rpre");
        issue(5'b10000, 8'h03, 8'h05, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rmul_c_before", {15'd0, flag_c}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("rmul_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        check("rmul_flags", {14'd0, flag_c, flag_z}, 16'd0);
        check("rmul_req_ready", {15'd0, req_ready}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rrel_req_ready", {15'd0, req_ready}, 16'd1);
        check("rrel_rsp_valid", {15'd0, rsp_valid}, 16'd0);
        issue(5'b00100, 8'h01, 8'h01, 1'b0);
        wait_rsp("radd", 2);
        check_rsp("radd", 8'h00, 8'h02, 1'b0, 1'b0);
        take_rsp("radd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
